// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state encoding for the multiply control FSM
package ctrl_pkg;

  localparam int         CTRL_NUM_STATES = 7;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SIGN = 3'd2;
  localparam logic [2:0] ST_LOOP = 3'd3;
  localparam logic [2:0] ST_FIX  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    SIGN = ST_SIGN,
    LOOP = ST_LOOP,
    FIX  = ST_FIX,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } ctrl_state_t;

  function automatic logic state_busy(input ctrl_state_t s);
    return (s == LOAD) || (s == SIGN) || (s == LOOP) || (s == FIX);
  endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// rtl/ctrl_unit_if.sv - control/datapath signal bundle for ctrl_unit
interface ctrl_unit_if;
  logic start;
  logic eqz1, neqz1, eqz2, neqz2;
  logic yes1, no1, yes2, no2;
  logic ld_a, ld_b, ld_z;
  logic clr_p, add_en, dec_z, neg_p;
  logic ld_s, dec_s;
  logic busy, done, err;

  modport master (
    input  start, eqz1, neqz1, eqz2, neqz2, yes1, no1, yes2, no2,
    output ld_a, ld_b, ld_z, clr_p, add_en, dec_z, neg_p, ld_s, dec_s,
           busy, done, err
  );

  modport slave (
    output start, eqz1, neqz1, eqz2, neqz2, yes1, no1, yes2, no2,
    input  ld_a, ld_b, ld_z, clr_p, add_en, dec_z, neg_p, ld_s, dec_s,
           busy, done, err
  );
endinterface

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - sign-magnitude multiply control FSM
// Optional loop watchdog enabled by defining CTRL_WATCHDOG_EN.
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic eqz1,
  input  logic neqz1,
  input  logic eqz2,
  input  logic neqz2,
  input  logic yes1,
  input  logic no1,
  input  logic yes2,
  input  logic no2,
  output logic ld_a,
  output logic ld_b,
  output logic ld_z,
  output logic clr_p,
  output logic add_en,
  output logic dec_z,
  output logic neg_p,
  output logic ld_s,
  output logic dec_s,
  output logic busy,
  output logic done,
  output logic err
);

`ifdef CTRL_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  logic        r_neg;
  logic        w_sign_bad;
  logic        w_wd_expired;
  logic        w_loop_stay;

  assign w_sign_bad   = (yes1 == no1) || (yes2 == no2);
  assign w_wd_expired = WD_EN && (eqz2 || neqz2) && !eqz1;
  // The exit cycle of LOOP issues no accumulate, so N iterations give N adds.
  assign w_loop_stay  = !neqz1 && !eqz1 && !w_wd_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == SIGN) begin
        r_neg <= no1 ^ no2;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: w_next = SIGN;
      SIGN: w_next = w_sign_bad ? ERR : LOOP;
      LOOP: begin
        if (neqz1)             w_next = ERR;
        else if (eqz1)         w_next = FIX;
        else if (w_wd_expired) w_next = ERR;
      end
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      ERR:  if (!start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_z   = 1'b0;
    clr_p  = 1'b0;
    add_en = 1'b0;
    dec_z  = 1'b0;
    neg_p  = 1'b0;
    ld_s   = 1'b0;
    dec_s  = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = state_busy(r_state);
    case (r_state)
      LOAD: begin
        ld_a  = 1'b1;
        ld_b  = 1'b1;
        ld_z  = 1'b1;
        clr_p = 1'b1;
        ld_s  = WD_EN;
      end
      LOOP: begin
        add_en = w_loop_stay;
        dec_z  = w_loop_stay;
        dec_s  = WD_EN && w_loop_stay;
      end
      FIX:  neg_p = r_neg;
      DONE: done  = 1'b1;
      ERR:  err   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// tb/tb_ctrl_unit.sv - self-checking bench for ctrl_unit with a counter-level datapath model
module tb_ctrl_unit;

  logic clk = 1'b0;
  logic rst_n;
  ctrl_unit_if u_if();

  always #5 clk = ~clk;

  ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .start(u_if.start),
    .eqz1(u_if.eqz1), .neqz1(u_if.neqz1), .eqz2(u_if.eqz2), .neqz2(u_if.neqz2),
    .yes1(u_if.yes1), .no1(u_if.no1), .yes2(u_if.yes2), .no2(u_if.no2),
    .ld_a(u_if.ld_a), .ld_b(u_if.ld_b), .ld_z(u_if.ld_z), .clr_p(u_if.clr_p),
    .add_en(u_if.add_en), .dec_z(u_if.dec_z), .neg_p(u_if.neg_p),
    .ld_s(u_if.ld_s), .dec_s(u_if.dec_s),
    .busy(u_if.busy), .done(u_if.done), .err(u_if.err)
  );

`ifdef CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int I_LDZ = 9, I_ADD = 7, I_NEG = 5, I_LDS = 4, I_DECS = 3;
  localparam int I_BUSY = 2, I_DONE = 1, I_ERR = 0;

  typedef struct packed {
    logic is_err;
    int   t_end;
    int   adds;
    logic negp;
  } exp_t;

  typedef struct packed {
    int         z0;
    int         s0;
    logic [3:0] sg;
    exp_t       e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int m_z = 0, m_s = 0, z_init = 0, s_init = 0, cyc_k = 0;
  logic [3:0]  sg_true = 4'b1010;
  logic [11:0] o_s;
  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic [11:0] outs();
    return {u_if.ld_a, u_if.ld_b, u_if.ld_z, u_if.clr_p, u_if.add_en, u_if.dec_z,
            u_if.neg_p, u_if.ld_s, u_if.dec_s, u_if.busy, u_if.done, u_if.err};
  endfunction

  function automatic logic [11:0] load_vec();
    return {4'b1111, 3'b000, WD, 1'b0, 1'b1, 2'b00};
  endfunction

  // Outcome of one operation derived from the counter rules, not from FSM states.
  function automatic exp_t predict(input int z0, input int s0, input logic [3:0] sg);
    exp_t e;
    e.negp = 1'b0;
    if (sg[3] == sg[2] || sg[1] == sg[0]) begin
      e.is_err = 1'b1; e.adds = 0; e.t_end = 3;
    end else if (z0 < 0) begin
      e.is_err = 1'b1; e.adds = 0; e.t_end = 4;
    end else if (z0 == 0 || !WD || z0 <= s0) begin
      e.is_err = 1'b0; e.adds = z0; e.t_end = z0 + 5; e.negp = sg[2] ^ sg[0];
    end else begin
      e.is_err = 1'b1; e.adds = (s0 > 0) ? s0 : 0; e.t_end = 4 + e.adds;
    end
    return e;
  endfunction

  function automatic vec_t mk(input int z0, input int s0, input logic [3:0] sg,
                              input logic is_err, input int t_end, input int adds,
                              input logic negp);
    vec_t v;
    v.z0 = z0; v.s0 = s0; v.sg = sg;
    v.e.is_err = is_err; v.e.t_end = t_end; v.e.adds = adds; v.e.negp = negp;
    return v;
  endfunction

  task automatic drive_flags(input int k);
    if (k < 2) begin
      {u_if.eqz1, u_if.neqz1, u_if.eqz2, u_if.neqz2} = 4'($urandom);
      {u_if.yes1, u_if.no1, u_if.yes2, u_if.no2}     = 4'($urandom);
    end else begin
      u_if.eqz1  = (m_z == 0);
      u_if.neqz1 = (m_z < 0);
      u_if.eqz2  = (m_s == 0);
      u_if.neqz2 = (m_s < 0);
      {u_if.yes1, u_if.no1, u_if.yes2, u_if.no2} = sg_true;
    end
  endtask

  // Sample one cycle at the falling edge, advance the counter model at the rising edge.
  task automatic tick();
    @(negedge clk);
    o_s = outs();
    @(posedge clk);
    if (o_s[I_LDZ]) m_z = z_init;
    else if (o_s[I_ADD]) m_z = m_z - 1;
    if (o_s[I_LDS]) m_s = s_init;
    else if (o_s[I_DECS]) m_s = m_s - 1;
    #1;
    cyc_k++;
    drive_flags(cyc_k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    u_if.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("in_reset_outs", int'(outs()), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_op(input string tag, input int z0, input int s0,
                        input logic [3:0] sg, input exp_t e, input bit jitter);
    int adds, busy_n, lds_n, decs_n, t_done, t_err;
    logic negp;
    adds = 0; busy_n = 0; lds_n = 0; decs_n = 0; t_done = -1; t_err = -1; negp = 1'b0;
    z_init = z0; s_init = s0; sg_true = sg; cyc_k = 0;
    u_if.start = 1'b1;
    drive_flags(0);
    for (int k = 0; k < 80; k++) begin
      tick();
      if (k == 0) check({tag, " idle_outs"}, int'(o_s), 0);
      if (k == 1) check({tag, " load_outs"}, int'(o_s), int'(load_vec()));
      adds   += int'(o_s[I_ADD]);
      busy_n += int'(o_s[I_BUSY]);
      lds_n  += int'(o_s[I_LDS]);
      decs_n += int'(o_s[I_DECS]);
      if (o_s[I_NEG]) negp = 1'b1;
      if (o_s[I_DONE] && t_done < 0) t_done = k;
      if (o_s[I_ERR] && t_err < 0) t_err = k;
      if (t_done >= 0 || t_err >= 0) break;
      if (k + 1 < e.t_end) u_if.start = jitter ? 1'($urandom) : 1'b0;
      else u_if.start = e.is_err;
    end
    check({tag, " is_err"}, int'(t_err >= 0), int'(e.is_err));
    check({tag, " end_cycle"}, e.is_err ? t_err : t_done, e.t_end);
    check({tag, " adds"}, adds, e.adds);
    check({tag, " neg_p"}, int'(negp), int'(e.negp));
    check({tag, " busy_cycles"}, busy_n, e.t_end - 1);
    check({tag, " ld_s_cycles"}, lds_n, int'(WD));
    check({tag, " dec_s_cycles"}, decs_n, WD ? e.adds : 0);
    if (e.is_err) begin
      tick();
      check({tag, " err_held"}, int'(o_s[I_ERR]), 1);
      u_if.start = 1'b0;
      tick();
      check({tag, " err_last"}, int'(o_s[I_ERR]), 1);
      tick();
      check({tag, " err_exit_outs"}, int'(o_s), 0);
    end else begin
      tick();
      check({tag, " post_done_outs"}, int'(o_s), 0);
    end
    u_if.start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench exceeded its time limit");
    $fatal(1);
  end

  initial begin
    bit y1, y2;
    int z0, s0;
    logic [3:0] sg;
    rst_n = 1'b0;
    u_if.start = 1'b0;
    {u_if.eqz1, u_if.neqz1, u_if.eqz2, u_if.neqz2} = 4'b0000;
    {u_if.yes1, u_if.no1, u_if.yes2, u_if.no2} = 4'b1010;

    // sg = {yes1, no1, yes2, no2}
    tbl[0] = mk(3, 20, 4'b1010, 1'b0, 8, 3, 1'b0);
    tbl[1] = mk(2, 20, 4'b0110, 1'b0, 7, 2, 1'b1);
    tbl[2] = mk(2, 20, 4'b1110, 1'b1, 3, 0, 1'b0);
    if (WD) tbl[3] = mk(10, 4, 4'b1010, 1'b1, 8, 4, 1'b0);
    else    tbl[3] = mk(10, 4, 4'b1010, 1'b0, 15, 10, 1'b0);
    tbl[4] = mk(0, 20, 4'b1010, 1'b0, 5, 0, 1'b0);
    tbl[5] = mk(1, 20, 4'b0101, 1'b0, 6, 1, 1'b0);
    tbl[6] = mk(-1, 20, 4'b1010, 1'b1, 4, 0, 1'b0);
    tbl[7] = mk(2, 20, 4'b1000, 1'b1, 3, 0, 1'b0);
    tbl[8] = mk(4, 4, 4'b1001, 1'b0, 9, 4, 1'b1);

    do_reset();

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].z0, tbl[i].s0, tbl[i].sg, tbl[i].e, 1'b0);
    end

    // Reset asserted on the second LOOP cycle, then a clean run.
    z_init = 5; s_init = 20; sg_true = 4'b1010; cyc_k = 0;
    drive_flags(0);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midloop loop2_add_en", int'(o_s[I_ADD]), 1);
    rst_n = 1'b1;
    tick();
    check("midloop after_reset_outs", int'(o_s), 0);
    run_op("after_reset", tbl[0].z0, tbl[0].s0, tbl[0].sg, tbl[0].e, 1'b0);

    // start held high across DONE begins a second operation.
    z_init = 1; s_init = 20; sg_true = 4'b1010; cyc_k = 0;
    drive_flags(0);
    u_if.start = 1'b1;
    repeat (6) tick();
    tick();
    check("b2b done_pulse", int'(o_s[I_DONE]), 1);
    tick();
    check("b2b idle_gap_outs", int'(o_s), 0);
    tick();
    check("b2b second_load_outs", int'(o_s), int'(load_vec()));
    u_if.start = 1'b0;
    repeat (4) tick();
    tick();
    check("b2b second_done", int'(o_s[I_DONE]), 1);
    tick();
    check("b2b final_idle_outs", int'(o_s), 0);

    for (int r = 0; r < 25; r++) begin
      z0 = $urandom_range(0, 14) - 1;
      s0 = $urandom_range(0, 14) - 1;
      y1 = 1'($urandom);
      y2 = 1'($urandom);
      sg = ($urandom_range(0, 4) == 0) ? 4'($urandom) : {y1, ~y1, y2, ~y2};
      run_op($sformatf("rnd%0d", r), z0, s0, sg, predict(z0, s0, sg), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
